// File: rtl/b11_scrambler.sv
// b11_scrambler: sequential string scrambler (ITC'99 b11 behaviour).
// Captures 6-bit characters from x_in while stbi is high and processes the
// last one when stbi drops. Characters 1..26 go through a multi-step signed
// arithmetic path driven by a wrapping counter; 0 and 63 bump the counter
// and are echoed; 27..62 are dropped.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset
//   x_in   - input character
//   stbi   - hold strobe, 1 keeps the FSM sampling in DATAIN
//   __obs  - observation strobe for the stimulus harness, no functional effect
//   x_out  - registered scrambled result
module b11_scrambler (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] x_in,
  input  logic       stbi,
  input  logic       __obs,
  output logic [5:0] x_out
);

  localparam int unsigned CHAR_W   = 6;
  localparam int unsigned CONT_W   = 5;
  localparam int unsigned ACC_W    = 9;
  localparam int unsigned CONT_MAX = 25;
  localparam int unsigned MUL_MAX  = 26;

  localparam logic signed [ACC_W-1:0] SUB_K = ACC_W'(21);
  localparam logic signed [ACC_W-1:0] ADD_K = ACC_W'(42);

  typedef enum logic [3:0] {
    S_RESET,
    S_DATAIN,
    S_SPAZIO,
    S_MUL,
    S_SOMMA,
    S_RSUM,
    S_RSOT,
    S_COMPL,
    S_DATAOUT
  } state_t;

  state_t                   state, state_nxt;
  logic [CHAR_W-1:0]        r_in, r_in_nxt;
  logic [CONT_W-1:0]        cont, cont_nxt;
  logic signed [ACC_W-1:0]  cont1, cont1_nxt;
  logic [CHAR_W-1:0]        x_out_nxt;
  logic signed [ACC_W-1:0]  r_in_ext;
  logic signed [ACC_W-1:0]  cont_ext;

  // Harness-only strobe: kept as a named sink so it survives as a port.
  logic unused_obs;
  assign unused_obs = __obs;

  // Zero-extended signed views of the unsigned registers.
  assign r_in_ext = $signed(ACC_W'(r_in));
  assign cont_ext = $signed(ACC_W'(cont));

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_RESET;
      r_in  <= '0;
      cont  <= '0;
      cont1 <= '0;
      x_out <= '0;
    end else begin
      state <= state_nxt;
      r_in  <= r_in_nxt;
      cont  <= cont_nxt;
      cont1 <= cont1_nxt;
      x_out <= x_out_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    r_in_nxt  = r_in;
    cont_nxt  = cont;
    cont1_nxt = cont1;
    x_out_nxt = x_out;

    case (state)
      S_RESET: begin
        cont_nxt  = '0;
        r_in_nxt  = x_in;
        x_out_nxt = '0;
        state_nxt = S_DATAIN;
      end
      S_DATAIN: begin
        r_in_nxt  = x_in;
        state_nxt = stbi ? S_DATAIN : S_SPAZIO;
      end
      S_SPAZIO: begin
        if (r_in == '0 || r_in == '1) begin
          // Delimiter characters advance the wrapping counter and echo.
          cont_nxt  = (cont < CONT_W'(CONT_MAX)) ? cont + CONT_W'(1) : '0;
          cont1_nxt = r_in_ext;
          state_nxt = S_DATAOUT;
        end else if (r_in <= CHAR_W'(MUL_MAX)) begin
          state_nxt = S_MUL;
        end else begin
          state_nxt = S_DATAIN;
        end
      end
      S_MUL: begin
        cont1_nxt = r_in[0] ? cont_ext + cont_ext : cont_ext;
        state_nxt = S_SOMMA;
      end
      S_SOMMA: begin
        state_nxt = r_in[1] ? S_RSUM : S_RSOT;
      end
      S_RSUM: begin
        cont1_nxt = r_in_ext + cont1;
        state_nxt = S_COMPL;
      end
      S_RSOT: begin
        // May go negative; range stays within 9-bit signed.
        cont1_nxt = r_in_ext - cont1;
        state_nxt = S_COMPL;
      end
      S_COMPL: begin
        cont1_nxt = r_in[2] ? cont1 - SUB_K : cont1 + ADD_K;
        state_nxt = S_DATAOUT;
      end
      S_DATAOUT: begin
        // Low six bits give the two's-complement value mod 64.
        x_out_nxt = cont1[CHAR_W-1:0];
        state_nxt = S_DATAIN;
      end
      default: begin
        state_nxt = S_RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_b11_scrambler.sv
// Directed bench for b11_scrambler with a reference model and a queue
// scoreboard: expected x_out is pushed when a character is launched and
// popped when the DUT's output edge has passed.
module tb_b11_scrambler;

  logic       clock;
  logic       reset;
  logic [5:0] x_in;
  logic       stbi;
  logic       obs;
  logic [5:0] x_out;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  int         cont_m = 0;
  logic [5:0] xo_m   = '0;
  logic [5:0] sb_q[$];

  b11_scrambler dut (
    .clock (clock),
    .reset (reset),
    .x_in  (x_in),
    .stbi  (stbi),
    .__obs (obs),
    .x_out (x_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [5:0] observed,
                       input logic [5:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  // Reference behaviour for one character; updates the counter model.
  task automatic model_step(input logic [5:0] ch, output logic [5:0] exp_o,
                            output int lat);
    int c1;
    if (ch == 6'd0 || ch == 6'd63) begin
      cont_m = (cont_m < 25) ? cont_m + 1 : 0;
      exp_o  = ch;
      lat    = 3;
    end else if (ch <= 6'd26) begin
      c1    = ch[0] ? cont_m * 2 : cont_m;
      c1    = ch[1] ? int'(ch) + c1 : int'(ch) - c1;
      c1    = ch[2] ? c1 - 21 : c1 + 42;
      exp_o = 6'(c1);
      lat   = 7;
    end else begin
      exp_o = xo_m;
      lat   = 2;
    end
  endtask

  // Launch a character from DATAIN; returns with the FSM back in DATAIN.
  task automatic send(input logic [5:0] ch);
    logic [5:0] e;
    int         lat;
    x_in = ch;
    stbi = 1'b0;
    obs  = ~obs;
    model_step(ch, e, lat);
    sb_q.push_back(e);
    for (int i = 1; i < lat; i++) begin
      @(negedge clock);
      x_in = 6'($urandom);   // ignored outside DATAIN
      if (i == lat - 1) check($sformatf("early_%0d", ch), x_out, xo_m);
    end
    @(negedge clock);
    if (sb_q.size() == 0) begin
      n_checks++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      check($sformatf("out_%0d", ch), x_out, e);
      xo_m = e;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clock);
    check("reset_xout", x_out, 6'd0);
    reset = 1'b1;
    stbi  = 1'b1;
    @(negedge clock);   // RESET edge
    cont_m = 0;
    xo_m   = '0;
  endtask

  initial begin
    logic [5:0] hold_v[5];
    reset = 1'b0;
    x_in  = '0;
    stbi  = 1'b1;
    obs   = 1'b0;
    repeat (2) @(negedge clock);
    do_reset();

    send(6'd5);          // 48
    send(6'd2);          // 44

    // Reset asserted while the FSM sits in MUL.
    x_in = 6'd5;
    stbi = 1'b0;
    @(negedge clock);    // -> SPAZIO
    @(negedge clock);    // -> MUL
    #2 reset = 1'b0;
    #1 check("async_reset_xout", x_out, 6'd0);
    @(negedge clock);
    reset = 1'b1;
    stbi  = 1'b1;
    @(negedge clock);
    cont_m = 0;
    xo_m   = '0;

    send(6'd5);          // 48, counter restarted
    send(6'd63);         // 63, counter -> 1
    send(6'd3);          // 47
    send(6'd40);         // rejected, holds 47

    // Hold strobe while x_in wanders; only the release value is processed.
    hold_v = '{6'd40, 6'd7, 6'd63, 6'd12, 6'd0};
    stbi = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x_in = hold_v[i];
      @(negedge clock);
      check($sformatf("stbi_hold_%0d", i), x_out, xo_m);
    end
    send(6'd21);         // 62 with counter 1

    // Counter wrap: 25 zeros reach 25, probe, one more zero wraps to 0.
    do_reset();
    for (int i = 0; i < 25; i++) send(6'd0);
    send(6'd1);          // 57 with counter 25
    send(6'd0);
    send(6'd1);          // 43 with counter 0

    for (int i = 0; i < 6; i++) send(6'($urandom_range(0, 63)));

    if (sb_q.size() != 0) begin
      n_checks++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/b11_scrambler.md
# b11_scrambler

Sequential string scrambler, functionally the ITC'99 b11 benchmark. It accepts 6-bit characters strobed by `stbi` and, for selected characters, computes a scrambled 6-bit code from the character and an internal wrapping counter. The result is presented on a registered output. It sits as a standalone top-level DUT under a concolic/stimulus harness.

## Interface
- No parameters.
- `clock` input 1: rising-edge clock, sole clock domain.
- `reset` input 1: asynchronous, active-low reset.
- `x_in` input 6: input character.
- `stbi` input 1: hold strobe; 1 keeps the FSM sampling in DATAIN.
- `__obs` input 1: observation strobe for verification; it has no functional effect and must not be optimised into logic.
- `x_out` output 6: registered scrambled result.

## Operation
- Registers:
  - `state` (9 states).
  - `r_in` [5:0]: captured character.
  - `cont`: counter, 0..25.
  - `cont1`: signed 9-bit accumulator.
  - `x_out` [5:0].
- Reset (`reset`=0, asynchronous): `state`=RESET, `r_in`=0, `cont`=0, `cont1`=0, `x_out`=0.
- FSM, one transition per rising edge:
  - RESET: `cont`←0; `r_in`←`x_in`; `x_out`←0; → DATAIN.
  - DATAIN: `r_in`←`x_in`. If `stbi`=1, stay in DATAIN; else → SPAZIO.
  - SPAZIO:
    - If `r_in`=0 or `r_in`=63: `cont`←(`cont`<25 ? `cont`+1 : 0); `cont1`←`r_in`; → DATAOUT.
    - Else if `r_in`≤26: → MUL.
    - Else (27..62): → DATAIN; `x_out` unchanged.
  - MUL: `cont1`←(`r_in`[0] ? `cont`×2 : `cont`); → SOMMA.
  - SOMMA: → RSUM if `r_in`[1]=1, else → RSOT.
  - RSUM: `cont1`←`r_in`+`cont1`; → COMPL.
  - RSOT: `cont1`←`r_in`−`cont1` (may go negative); → COMPL.
  - COMPL: `cont1`←(`r_in`[2] ? `cont1`−21 : `cont1`+42); → DATAOUT.
  - DATAOUT: `x_out`←`cont1`[5:0], i.e. two's-complement value mod 64; → DATAIN.
- Arithmetic is signed, at least 9 bits. Value range is −70..118, so no overflow occurs.
- `cont` changes only in RESET and SPAZIO.
- `x_out` changes only in RESET and DATAOUT.

## Timing
- Edges are counted from the DATAIN edge that sees `stbi`=0 (edge 1).
- Compute path (`r_in` 1..26): DATAIN → SPAZIO → MUL → SOMMA → RSUM/RSOT → COMPL → DATAOUT. `x_out` updates on edge 7. The FSM is back in DATAIN after edge 7 and samples again on edge 8.
- Fast path (`r_in` 0 or 63): `x_out` updates on edge 3.
- Rejected path (`r_in` 27..62): back in DATAIN after edge 2, with no output change.
- `x_in` is sampled only in RESET and DATAIN. Changes during the other states are ignored.
- Reset asserted mid-computation aborts immediately and forces all reset values.
- The first edge after reset release executes RESET, so DATAIN is active from the second edge.

## Test plan
- Reset, then `x_in`=5, `stbi`=0 → `x_out`=48 after 7 edges from DATAIN. Path: `cont1`=0, RSOT gives 5, minus 21 gives −16.
- Reset, then `x_in`=2 → `x_out`=44. Path: RSUM gives 2, plus 42.
- Reset, then `x_in`=63 → `x_out`=63 after 3 edges and `cont`=1. Follow with `x_in`=3 → `x_out`=47. Path: `cont1`=2, plus 3 gives 5, plus 42.
- `x_in`=40 → FSM returns to DATAIN after 2 edges; `x_out` keeps its previous value.
- `stbi` held at 1 for 5 cycles while `x_in` changes → FSM stays in DATAIN. On release, the last `x_in` is the one processed.
- Counter wrap: 26 consecutive `x_in`=0 characters → `cont` goes 1..25 then 0.
- Async reset: assert `reset`=0 during MUL → `x_out`=0 immediately, and the FSM is in RESET.
